// File: rtl/sync_sp_mem.sv
// Single-port synchronous memory: byte-enabled writes, 1- or 2-cycle registered read, rd_valid strobe.
// Optional per-byte even parity with error injection when SYNC_SP_MEM_PARITY_EN is defined.
`default_nettype none

module sync_sp_mem #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int INIT_COUNT   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
`ifdef SYNC_SP_MEM_PARITY_EN
  input  logic                      wr_par_flip,
  output logic                      rd_par_err,
`endif
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
`ifdef SYNC_SP_MEM_PARITY_EN
  localparam int PW    = NB;
`else
  localparam int PW    = 0;
`endif
  // Each entry holds data in the low bits, parity bit for byte b at DATA_WIDTH+b.
  localparam int EW    = DATA_WIDTH + PW;

  function automatic logic [DEPTH-1:0][EW-1:0] f_init();
    logic [DEPTH-1:0][EW-1:0] m;
    logic [DATA_WIDTH-1:0]    d;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < INIT_COUNT) begin
        d = DATA_WIDTH'(i);
        m[ADDR_WIDTH'(i)][DATA_WIDTH-1:0] = d;
`ifdef SYNC_SP_MEM_PARITY_EN
        for (int b = 0; b < NB; b++)
          m[ADDR_WIDTH'(i)][DATA_WIDTH+b] = ^d[b*8 +: 8];
`endif
      end
    end
    return m;
  endfunction

  logic [DEPTH-1:0][EW-1:0] r_mem = f_init();

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_en;
  logic [EW-1:0]         w_rd_word;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Array is deliberately outside reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (req && we) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          r_mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
`ifdef SYNC_SP_MEM_PARITY_EN
          r_mem[addr][DATA_WIDTH+b] <= (^wr_data[b*8 +: 8]) ^ wr_par_flip;
`endif
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign w_rd_addr = addr;
      assign w_rd_en   = req & ~we;
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic [ADDR_WIDTH-1:0] r_addr;
      logic                  r_vld_pipe;
      // Address loads every cycle; r_vld_pipe masks the non-read cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_addr     <= '0;
          r_vld_pipe <= 1'b0;
        end else begin
          r_addr     <= addr;
          r_vld_pipe <= req & ~we;
        end
      end
      assign w_rd_addr = r_addr;
      assign w_rd_en   = r_vld_pipe;
    end else begin : g_bad_latency
      $error("sync_sp_mem: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  assign w_rd_word = r_mem[w_rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) r_rd_data <= w_rd_word[DATA_WIDTH-1:0];
    end
  end

`ifdef SYNC_SP_MEM_PARITY_EN
  logic w_par_bad;
  logic r_par_err;

  always_comb begin
    w_par_bad = 1'b0;
    for (int b = 0; b < NB; b++)
      w_par_bad = w_par_bad | (^{w_rd_word[DATA_WIDTH+b], w_rd_word[b*8 +: 8]});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= w_rd_en & w_par_bad;
  end

  assign rd_par_err = r_par_err;
`endif

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_sync_sp_mem.sv
// Directed bench: three instances (8-bit lat2, 32-bit lat2, 8-bit lat1) share one request stream.
// Parity checks are compiled in when SYNC_SP_MEM_PARITY_EN is defined.
module tb_sync_sp_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        wr_par_flip = 1'b0;

  logic [7:0]  rd_data2, rd_data1;
  logic [31:0] rd_data32;
  logic        rd_valid2, rd_valid1, rd_valid32;
  logic        par_err2, par_err1, par_err32;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_sp_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(2), .INIT_COUNT(20)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
`ifdef SYNC_SP_MEM_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_par_err(par_err2),
`endif
    .rd_data(rd_data2), .rd_valid(rd_valid2));

  sync_sp_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2), .INIT_COUNT(20)) u_dut32 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be),
`ifdef SYNC_SP_MEM_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_par_err(par_err32),
`endif
    .rd_data(rd_data32), .rd_valid(rd_valid32));

  sync_sp_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1), .INIT_COUNT(20)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wr_data(wr_data[7:0]), .wr_be(wr_be[0:0]),
`ifdef SYNC_SP_MEM_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_par_err(par_err1),
`endif
    .rd_data(rd_data1), .rd_valid(rd_valid1));

`ifndef SYNC_SP_MEM_PARITY_EN
  assign par_err2  = 1'b0;
  assign par_err32 = 1'b0;
  assign par_err1  = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    req = 1'b1; we = 1'b0; addr = a; wr_be = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic flip);
    req = 1'b1; we = 1'b1; addr = a; wr_data = d; wr_be = be; wr_par_flip = flip;
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b1; addr = 8'hFF; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF; wr_par_flip = 1'b0;
  endtask

  initial begin
    idle();
    step(); step();
    chk("reset_valid2",  {31'd0, rd_valid2},  32'd0);
    chk("reset_data2",   {24'd0, rd_data2},   32'd0);
    chk("reset_valid1",  {31'd0, rd_valid1},  32'd0);
    chk("reset_data32",  rd_data32,           32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_valid", {31'd0, rd_valid2 | rd_valid1 | rd_valid32}, 32'd0);

    // Single read of an initialised entry
    rd(8'h05); step(); idle();
    chk("rd5_l2_n1_valid", {31'd0, rd_valid2}, 32'd0);
    chk("rd5_l1_n1_valid", {31'd0, rd_valid1}, 32'd1);
    chk("rd5_l1_n1_data",  {24'd0, rd_data1},  32'h05);
    step();
    chk("rd5_l2_n2_valid", {31'd0, rd_valid2}, 32'd1);
    chk("rd5_l2_n2_data",  {24'd0, rd_data2},  32'h05);
    chk("rd5_32_n2_data",  rd_data32,          32'h05);
    chk("rd5_l1_n2_valid", {31'd0, rd_valid1}, 32'd0);
    step();
    chk("rd5_l2_n3_valid", {31'd0, rd_valid2}, 32'd0);
    chk("rd5_l2_hold",     {24'd0, rd_data2},  32'h05);

    // Last initialised entry
    rd(8'h13); step(); idle();
    chk("rd13_l1_data", {24'd0, rd_data1}, 32'h13);

    // Byte-enabled writes, a wr_be=0 no-op, then read back
    wr(8'h10, 32'hAABB_CCDD, 4'hF, 1'b0); step();
    wr(8'h10, 32'h1122_3344, 4'h5, 1'b0); step();
    chk("wr_no_valid2", {31'd0, rd_valid2}, 32'd0);
    wr(8'h10, 32'hFFFF_FFFF, 4'h0, 1'b0); step();
    chk("wr_no_valid1", {31'd0, rd_valid1}, 32'd0);
    chk("wr_hold_data1", {24'd0, rd_data1}, 32'h13);
    rd(8'h10); step(); idle();
    chk("be_l1_data", {24'd0, rd_data1}, 32'h44);
    step();
    chk("be_32_valid", {31'd0, rd_valid32}, 32'd1);
    chk("be_32_data",  rd_data32,           32'hAA22_CC44);
    chk("be_l2_data",  {24'd0, rd_data2},   32'h44);

    // Latency-1 read right after a write sees the new value
    wr(8'h30, 32'h0000_005A, 4'h1, 1'b0); step();
    rd(8'h30); step(); idle();
    chk("l1_rdaw_data", {24'd0, rd_data1}, 32'h5A);
    step();

    // Back-to-back reads 1,2,3
    rd(8'h01); step();
    chk("b2b_n1_l1", {23'd0, rd_valid1, rd_data1}, {23'd0, 1'b1, 8'h01});
    chk("b2b_n1_l2v", {31'd0, rd_valid2}, 32'd0);
    rd(8'h02); step();
    chk("b2b_n2_l1", {23'd0, rd_valid1, rd_data1}, {23'd0, 1'b1, 8'h02});
    chk("b2b_n2_l2", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b1, 8'h01});
    rd(8'h03); step(); idle();
    chk("b2b_n3_l1", {23'd0, rd_valid1, rd_data1}, {23'd0, 1'b1, 8'h03});
    chk("b2b_n3_l2", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b1, 8'h02});
    step();
    chk("b2b_n4_l1", {23'd0, rd_valid1, rd_data1}, {23'd0, 1'b0, 8'h03});
    chk("b2b_n4_l2", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b1, 8'h03});
    chk("b2b_n4_32", {31'd0, rd_valid32}, 32'd1);
    chk("b2b_n4_32d", rd_data32, 32'h03);
    step();
    chk("b2b_n5_l2", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b0, 8'h03});

    // Latency-2 read-first against a following write
    rd(8'h07); step();
    wr(8'h07, 32'h0000_007F, 4'h1, 1'b0); step(); idle();
    chk("rfirst_l2", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b1, 8'h07});
    rd(8'h07); step(); idle(); step();
    chk("reread_l2", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b1, 8'h7F});
    step();

    // Reset squashes an in-flight read
    rd(8'h03); step(); idle();
    rst = 1'b1;
    #1;
    chk("squash_data2",  {24'd0, rd_data2},  32'd0);
    chk("squash_valid2", {31'd0, rd_valid2}, 32'd0);
    chk("squash_valid1", {31'd0, rd_valid1}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_v1", {31'd0, rd_valid2 | rd_valid32}, 32'd0);
    step();
    chk("post_rst_v2", {31'd0, rd_valid2 | rd_valid32}, 32'd0);
    chk("post_rst_d2", {24'd0, rd_data2}, 32'd0);

    // Contents survive reset
    rd(8'h07); step(); idle(); step();
    chk("keep_after_rst", {23'd0, rd_valid2, rd_data2}, {23'd0, 1'b1, 8'h7F});

`ifdef SYNC_SP_MEM_PARITY_EN
    chk("par_init_ok", {31'd0, par_err2}, 32'd0);
    wr(8'h20, 32'h0000_003C, 4'h1, 1'b1); step();
    rd(8'h20); step(); idle();
    chk("par_l1_err", {31'd0, par_err1}, 32'd1);
    step();
    chk("par_flip_data", {24'd0, rd_data2}, 32'h3C);
    chk("par_flip_err",  {31'd0, par_err2}, 32'd1);
    step();
    chk("par_err_low_idle", {31'd0, par_err2}, 32'd0);
    wr(8'h20, 32'h0000_003C, 4'h1, 1'b0); step();
    rd(8'h20); step(); idle(); step();
    chk("par_ok_valid", {31'd0, rd_valid2}, 32'd1);
    chk("par_ok_err",   {31'd0, par_err2},  32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_sp_mem.md
Name: sync_sp_mem

Overview:
- Parametrised single-port synchronous memory with an initialisable array, byte-enabled writes and a selectable 1- or 2-cycle read pipeline.
- A read-valid strobe tracks each read through the pipeline.
- Generalises the fixed 256x8 registered-address ROM to arbitrary width and depth plus a write path.
- Used as a building block for register files, lookup tables and small scratchpads.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- READ_LATENCY, 2, cycles from read request to data; legal values 1 or 2. Any other value is an elaboration error.
- INIT_COUNT, 20, entries 0..INIT_COUNT-1 initialised to their own index (truncated to DATA_WIDTH); remaining entries are unspecified; 0 means no initialisation.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- req  input  1  access request this cycle.
- we  input  1  with req: 1 = write, 0 = read.
- addr  input  ADDR_WIDTH  access address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i gates bits [8i+7:8i].
- rd_data  output  DATA_WIDTH  read data, registered.
- rd_valid  output  1  one-cycle strobe: rd_data carries a new read result.

Behaviour:
- Reset (rst high, asynchronous):
  - rd_data = 0, rd_valid = 0, internal address register = 0, internal valid pipeline = 0.
  - Array contents are not affected by reset.
  - Reset mid-operation squashes in-flight reads; no rd_valid is produced for them after release.
- Write (req=1, we=1):
  - Bytes with wr_be[i]=1 at mem[addr] update at the rising edge ending the request cycle. Other bytes are unchanged.
  - wr_be = 0 is a legal no-op.
  - A write never produces rd_valid.
- Read (req=1, we=0), request in cycle N:
  - READ_LATENCY=1: array read with addr at edge N. rd_data and rd_valid=1 are visible in cycle N+1.
  - READ_LATENCY=2: addr is registered at edge N, array read at edge N+1 with the registered address. rd_data and rd_valid=1 are visible in cycle N+2.
- Pipelining: one access is accepted every cycle, with no stalls and no backpressure. Back-to-back reads give back-to-back rd_valid strobes in request order.
- rd_data holds its last read value while rd_valid=0. Idle cycles and writes do not change it.
- Write ordering, READ_LATENCY=2: if a write in cycle N+1 targets the address of a read requested in cycle N, the read returns the old data (read-first at the shared edge).
- Write ordering, READ_LATENCY=1: a read in cycle N+1 after a write in cycle N returns the new data.
- req=0: we, addr, wr_data and wr_be are ignored. The latency-2 address register may still load, but the result is masked because rd_valid stays low.
- Wrap-around: addresses are ADDR_WIDTH bits wide, so there is no out-of-range case.
- Initialisation is done by simulation/synthesis initial contents only; there is no runtime init sequencer.

Optional Feature:
- Macro: SYNC_SP_MEM_PARITY_EN.
- When defined:
  - The array stores one even-parity bit per byte, computed from the write data.
  - Added input wr_par_flip (1): on a write, inverts the stored parity bit of every enabled byte. Used for error injection.
  - Added output rd_par_err (1): asserted together with rd_valid when any byte of the read word fails its parity check. Reset value 0. Low whenever rd_valid is low.
  - Initialised entries get correct parity.
- When not defined: no parity storage, no wr_par_flip or rd_par_err ports, and no added logic or latency. Read timing is identical in both builds.

Test Plan:
- Reset, then read addr 0x05 at cycle N with READ_LATENCY=2 -> rd_valid=1 and rd_data=0x05 in cycle N+2 only; rd_data stays 0x05 afterwards.
- DATA_WIDTH=32: write 0xAABBCCDD to 0x10 with wr_be=0xF, then write 0x11223344 with wr_be=0x5, then read -> 0xAA22CC44 after READ_LATENCY cycles.
- Reads to 1,2,3 on consecutive cycles (latency 1 and 2) -> three consecutive rd_valid strobes with data 0x01, 0x02, 0x03; rd_valid=0 on the cycle after.
- READ_LATENCY=2: read 0x07 in cycle N, write 0x7F to 0x07 in cycle N+1 -> returns 0x07; a re-read returns 0x7F.
- Issue a read, then assert rst in the cycle before its data is due -> rd_data=0 and rd_valid=0 immediately; no strobe after release.
- SYNC_SP_MEM_PARITY_EN: write 0x3C with wr_par_flip=1, then read -> rd_data=0x3C with rd_par_err=1; rewrite with flip=0 and read -> rd_par_err=0.
